// File: rtl/boundary_scan_register_pkg.sv
// Shared types for the boundary-scan data register and its cells.
package boundary_scan_register_pkg;

  // Per-edge control bundle broadcast from the top level to every cell.
  typedef struct packed {
    logic cdr_evt;   // one-cycle capture/shift event (clock_dr rising)
    logic udr_evt;   // one-cycle update event (update_dr rising)
    logic shift_dr;  // 1 = shift on cdr_evt, 0 = capture on cdr_evt
    logic mode;      // 1 = drive pins from the update stage
  } bsr_ctrl_t;

endpackage

// File: rtl/boundary_scan_register_bsr_cell.sv
// One boundary-scan cell: capture/shift flop feeding an update (hold) flop,
// plus the normal/test output mux in front of the pin.
module bsr_cell
  import boundary_scan_register_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  bsr_ctrl_t ctrl_i,
  input  logic      data_i,
  input  logic      serial_i,
  output logic      data_o,
  output logic      serial_o
);

  logic cap_q, cap_d;
  logic upd_q, upd_d;

  // Next-state for both stages; update samples the pre-edge capture value.
  always_comb begin
    cap_d = cap_q;
    upd_d = upd_q;
    if (ctrl_i.cdr_evt) begin
      cap_d = ctrl_i.shift_dr ? serial_i : data_i;
    end
    if (ctrl_i.udr_evt) begin
      upd_d = cap_q;
    end
  end

  // Stage registers; reset clears both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      upd_q <= upd_d;
    end
  end

  assign serial_o = cap_q;
  assign data_o   = ctrl_i.mode ? upd_q : data_i;

endmodule

// File: rtl/boundary_scan_register.sv
// JTAG boundary-scan data register: strobe edge detection plus a chain of
// cells. scan_in enters the MSB cell, the LSB cell drives scan_out.
module boundary_scan_register
  import boundary_scan_register_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            system_clk,
  input  logic            reset,
  input  logic [size-1:0] data_in,
  output logic [size-1:0] data_out,
  input  logic            scan_in,
  output logic            scan_out,
  input  logic            shift_dr,
  input  logic            mode,
  input  logic            clock_dr,
  input  logic            update_dr
);

  logic      clk_dr_q, upd_dr_q;
  logic      cdr_evt, udr_evt;
  bsr_ctrl_t ctrl;
  logic [size:0] chain;

  // Strobe history; resets high so a strobe held high across reset is ignored.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      clk_dr_q <= 1'b1;
      upd_dr_q <= 1'b1;
    end else begin
      clk_dr_q <= clock_dr;
      upd_dr_q <= update_dr;
    end
  end

  assign cdr_evt = clock_dr & ~clk_dr_q;
  assign udr_evt = update_dr & ~upd_dr_q;

  assign ctrl.cdr_evt  = cdr_evt;
  assign ctrl.udr_evt  = udr_evt;
  assign ctrl.shift_dr = shift_dr;
  assign ctrl.mode     = mode;

  // Serial chain runs from the MSB cell down to the LSB cell.
  assign chain[size] = scan_in;
  assign scan_out    = chain[0];

  generate
    for (genvar gi = 0; gi < size; gi++) begin : g_cell
      bsr_cell u_cell (
        .clk      (system_clk),
        .reset    (reset),
        .ctrl_i   (ctrl),
        .data_i   (data_in[gi]),
        .serial_i (chain[gi+1]),
        .data_o   (data_out[gi]),
        .serial_o (chain[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_boundary_scan_register.sv
// Self-checking bench for boundary_scan_register: directed steps from the
// test plan, then randomized strobe transactions against a transaction-level
// model of the two register stages.
module tb_boundary_scan_register;

  localparam int SIZE = 8;

  logic            system_clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] data_in;
  logic [SIZE-1:0] data_out;
  logic            scan_in;
  logic            scan_out;
  logic            shift_dr;
  logic            mode;
  logic            clock_dr;
  logic            update_dr;

  int total = 0;
  int bad   = 0;

  // Reference state: contents of the capture/shift and update stages.
  logic [SIZE-1:0] m_shift;
  logic [SIZE-1:0] m_upd;

  boundary_scan_register #(.size(SIZE)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .shift_dr   (shift_dr),
    .mode       (mode),
    .clock_dr   (clock_dr),
    .update_dr  (update_dr)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare both outputs against the model.
  task automatic tick();
    logic [SIZE-1:0] exp_out;
    logic [SIZE-1:0] exp_so;
    @(posedge system_clk);
    #1;
    exp_out = mode ? m_upd : data_in;
    exp_so  = SIZE'(m_shift[0]);
    chk("data_out", data_out, exp_out);
    chk("scan_out", SIZE'(scan_out), exp_so);
  endtask

  // One strobe transaction: raise the selected strobes for 'width' cycles,
  // then drop them for one cycle. Exactly one action per transaction.
  task automatic pulse(input bit c, input bit u, input int width);
    logic [SIZE-1:0] old_shift;
    old_shift = m_shift;
    if (c) begin
      if (shift_dr) m_shift = (m_shift >> 1) | (SIZE'(scan_in) << (SIZE - 1));
      else          m_shift = data_in;
    end
    if (u) m_upd = old_shift;
    $display("txn cdr=%0b udr=%0b shift_dr=%0b scan_in=%0b width=%0d data_in=%h -> shift=%h upd=%h",
             c, u, shift_dr, scan_in, width, data_in, m_shift, m_upd);
    clock_dr  = c;
    update_dr = u;
    tick();
    for (int k = 1; k < width; k++) tick();
    clock_dr  = 1'b0;
    update_dr = 1'b0;
    tick();
  endtask

  // Reset with the given strobe levels, then one idle cycle with strobes low.
  task automatic do_reset(input bit strobes_high);
    $display("txn reset strobes_high=%0b", strobes_high);
    clock_dr  = strobes_high;
    update_dr = strobes_high;
    reset     = 1'b1;
    m_shift   = '0;
    m_upd     = '0;
    tick();
    reset = 1'b0;
    if (strobes_high) begin
      for (int k = 0; k < 3; k++) tick();  // held-high strobes must not act
    end
    clock_dr  = 1'b0;
    update_dr = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    clock_dr  = 1'b1;
    update_dr = 1'b1;
    data_in   = 8'h5A;
    mode      = 1'b0;
    shift_dr  = 1'b0;
    scan_in   = 1'b0;
    m_shift   = '0;
    m_upd     = '0;

    // Reset with strobes high.
    tick();
    tick();
    chk("rst_scan_out", SIZE'(scan_out), 8'h00);
    chk("rst_pass_through", data_out, 8'h5A);
    mode = 1'b1;
    #1;
    chk("rst_upd_zero", data_out, 8'h00);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_no_action_upd", data_out, 8'h00);
    clock_dr  = 1'b0;
    update_dr = 1'b0;
    tick();

    // Capture 8'hAA then update.
    mode     = 1'b0;
    data_in  = 8'hAA;
    shift_dr = 1'b0;
    pulse(1, 0, 1);
    chk("cap_scan_out", SIZE'(scan_out), 8'h00);
    pulse(0, 1, 1);
    mode = 1'b1;
    #1;
    chk("upd_aa", data_out, 8'hAA);

    // Shift eight ones in; LSB leaves first.
    shift_dr = 1'b1;
    scan_in  = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      chk($sformatf("shift_so_%0d", i), SIZE'(scan_out), SIZE'(i % 2));
      pulse(1, 0, 1);
    end
    chk("shift_final_so", SIZE'(scan_out), 8'h01);
    chk("shift_upd_held", data_out, 8'hAA);
    pulse(0, 1, 1);
    chk("upd_ff", data_out, 8'hFF);
    mode = 1'b0;
    #1;
    chk("normal_aa", data_out, 8'hAA);
    data_in = 8'h3C;
    #1;
    chk("normal_3c", data_out, 8'h3C);
    tick();

    // Long clock_dr pulse gives a single shift; coincident strobes.
    scan_in = 1'b0;
    pulse(1, 0, 5);
    chk("wide_so", SIZE'(scan_out), 8'h01);
    pulse(1, 1, 1);
    mode = 1'b1;
    #1;
    chk("coincident_upd", data_out, 8'h7F);
    tick();

    // Reset mid-shift, then resume.
    scan_in = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1, 0, 1);
    do_reset(1'b0);
    chk("midrst_upd", data_out, 8'h00);
    chk("midrst_so", SIZE'(scan_out), 8'h00);
    shift_dr = 1'b0;
    data_in  = 8'hC3;
    pulse(1, 0, 1);
    pulse(0, 1, 1);
    chk("resume_c3", data_out, 8'hC3);

    // Randomized transactions.
    for (int n = 0; n < 200; n++) begin
      int op;
      data_in  = SIZE'($urandom);
      mode     = 1'($urandom);
      shift_dr = 1'($urandom);
      scan_in  = 1'($urandom);
      #1;
      chk("rand_comb", data_out, mode ? m_upd : data_in);
      op = $urandom_range(0, 9);
      case (op)
        0:       do_reset(1'($urandom));
        1, 2, 3: pulse(1, 0, $urandom_range(1, 4));
        4, 5:    pulse(0, 1, $urandom_range(1, 4));
        6, 7:    pulse(1, 1, $urandom_range(1, 4));
        default: tick();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
